// File: rtl/sprite_compositor.sv
// ============================================================================
// Module   : sprite_compositor
// Function : N-sprite pixel compositor with frame-latched attributes, a fixed
//            3-cycle ROM address/read/resolve pipeline and colour-key priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_compositor #(
    parameter int NUM_SPRITES = 2,
    parameter int SPR_W       = 150,
    parameter int SPR_H       = 157,
    parameter int NUM_FRAMES  = 16,
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 8'hE3,
    parameter logic [COLOR_W-1:0] BG_COLOR    = 8'h3B,
    localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int ADDR_W  = $clog2(NUM_FRAMES * SPR_W * SPR_H),
    localparam int ID_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic                           pixel_valid,
    input  logic [COORD_W-1:0]             pixel_x,
    input  logic [COORD_W-1:0]             pixel_y,
    input  logic [NUM_SPRITES*COORD_W-1:0] pos_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] pos_y,
    input  logic [NUM_SPRITES*FRAME_W-1:0] frame_sel,
    input  logic [NUM_SPRITES-1:0]         flip,
    input  logic [NUM_SPRITES-1:0]         enable,
    output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
    input  logic [NUM_SPRITES*COLOR_W-1:0] rom_q,
    output logic                           out_valid,
    output logic                           visible,
    output logic [ID_W-1:0]                sprite_id,
    output logic [COLOR_W-1:0]             data
);

    localparam logic [31:0] C_SPR_W     = 32'(SPR_W);
    localparam logic [31:0] C_SPR_H     = 32'(SPR_H);
    localparam logic [31:0] C_FRAME_PIX = 32'(SPR_W * SPR_H);

    logic [NUM_SPRITES*COORD_W-1:0] shadow_pos_x_q, shadow_pos_y_q;
    logic [NUM_SPRITES*FRAME_W-1:0] shadow_frame_q;
    logic [NUM_SPRITES-1:0]         shadow_flip_q, shadow_en_q;

    logic [NUM_SPRITES*COORD_W-1:0] w_pos_x, w_pos_y;
    logic [NUM_SPRITES*FRAME_W-1:0] w_frame;
    logic [NUM_SPRITES-1:0]         w_flip, w_en;

    logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [NUM_SPRITES-1:0]         hit1_q, hit1_d, hit2_q;
    logic                           valid1_q, valid2_q;
    logic [NUM_SPRITES-1:0]         w_opaque;

    logic                           out_valid_q, visible_q, visible_d;
    logic [ID_W-1:0]                sprite_id_q, sprite_id_d;
    logic [COLOR_W-1:0]             data_q, data_d;

    // A frame_start coinciding with a pixel makes that pixel see the new attributes
    assign w_pos_x = frame_start ? pos_x     : shadow_pos_x_q;
    assign w_pos_y = frame_start ? pos_y     : shadow_pos_y_q;
    assign w_frame = frame_start ? frame_sel : shadow_frame_q;
    assign w_flip  = frame_start ? flip      : shadow_flip_q;
    assign w_en    = frame_start ? enable    : shadow_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_pos_x_q <= '0;
            shadow_pos_y_q <= '0;
            shadow_frame_q <= '0;
            shadow_flip_q  <= '0;
            shadow_en_q    <= '0;
        end else if (frame_start) begin
            shadow_pos_x_q <= pos_x;
            shadow_pos_y_q <= pos_y;
            shadow_frame_q <= frame_sel;
            shadow_flip_q  <= flip;
            shadow_en_q    <= enable;
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
        logic [COORD_W-1:0] w_px, w_py;
        logic [COORD_W:0]   w_rx, w_ry;
        logic [31:0]        w_rx32, w_ry32, w_col, w_frame32, w_addr_full;
        logic               w_hit;

        assign w_px      = w_pos_x[i*COORD_W +: COORD_W];
        assign w_py      = w_pos_y[i*COORD_W +: COORD_W];
        // The extra bit plus the >= tests stop a sprite near the edge wrapping to column 0
        assign w_rx      = {1'b0, pixel_x} - {1'b0, w_px};
        assign w_ry      = {1'b0, pixel_y} - {1'b0, w_py};
        assign w_rx32    = 32'(w_rx);
        assign w_ry32    = 32'(w_ry);
        assign w_frame32 = 32'(w_frame[i*FRAME_W +: FRAME_W]);

        assign w_hit = w_en[i] & pixel_valid & (pixel_x >= w_px) & (pixel_y >= w_py)
                     & (w_rx32 < C_SPR_W) & (w_ry32 < C_SPR_H);

        assign w_col       = w_flip[i] ? (C_SPR_W - 32'd1 - w_rx32) : w_rx32;
        assign w_addr_full = w_frame32 * C_FRAME_PIX + w_ry32 * C_SPR_W + w_col;

        // Address is held on a miss to avoid needless ROM bus toggling
        assign rom_addr_d[i*ADDR_W +: ADDR_W] = w_hit ? ADDR_W'(w_addr_full)
                                                      : rom_addr_q[i*ADDR_W +: ADDR_W];
        assign hit1_d[i]   = w_hit;
        assign w_opaque[i] = hit2_q[i] & (rom_q[i*COLOR_W +: COLOR_W] != TRANSPARENT);
    end

    // Descending scan so the lowest opaque index is the one that sticks
    always_comb begin
        visible_d   = 1'b0;
        sprite_id_d = '0;
        data_d      = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                visible_d   = 1'b1;
                sprite_id_d = ID_W'(i);
                data_d      = rom_q[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q  <= '0;
            hit1_q      <= '0;
            valid1_q    <= 1'b0;
            hit2_q      <= '0;
            valid2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            visible_q   <= 1'b0;
            sprite_id_q <= '0;
            data_q      <= BG_COLOR;
        end else begin
            rom_addr_q  <= rom_addr_d;
            hit1_q      <= hit1_d;
            valid1_q    <= pixel_valid;
            hit2_q      <= hit1_q;
            valid2_q    <= valid1_q;
            out_valid_q <= valid2_q;
            visible_q   <= visible_d;
            sprite_id_q <= sprite_id_d;
            data_q      <= data_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign visible   = visible_q;
    assign sprite_id = sprite_id_q;
    assign data      = data_q;

endmodule

`default_nettype wire

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised multi-sprite pixel compositor for the VGA render path. It replaces the fixed two-player sprite lookup with N sprites, each having a frame index, a horizontal-flip option and a per-sprite enable. All sprite attributes are latched at frame start, which prevents tearing. The block generates ROM addresses through a fixed 3-cycle pipeline and resolves overlapping sprites by priority, with transparency. It sits between the VGA timing generator and the colour output stage; the sprite ROMs are external and stay outside this block.

## Interface
Parameters:
- NUM_SPRITES, 2: number of sprite channels; index 0 has the highest priority.
- SPR_W, 150: sprite width in pixels.
- SPR_H, 157: sprite height in pixels.
- NUM_FRAMES, 16: frames per sprite ROM. FRAME_W = clog2(NUM_FRAMES).
- COORD_W, 10: pixel and position coordinate width.
- COLOR_W, 8: pixel colour width.
- TRANSPARENT, 8'hE3: colour key treated as transparent.
- BG_COLOR, 8'h3B: data output when no sprite is visible.
- ADDR_W is derived as clog2(NUM_FRAMES*SPR_W*SPR_H).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that latches all sprite attributes into shadow registers.
- pixel_valid  in  1  pixel_x/pixel_y are valid this cycle.
- pixel_x, pixel_y  in  COORD_W each  current pixel coordinates.
- pos_x, pos_y  in  NUM_SPRITES*COORD_W each  top-left corner of each sprite, flattened; sprite i occupies bits [i*COORD_W +: COORD_W].
- frame_sel  in  NUM_SPRITES*FRAME_W  frame index for each sprite.
- flip  in  NUM_SPRITES  horizontal mirror for each sprite.
- enable  in  NUM_SPRITES  sprite is drawn.
- rom_addr  out  NUM_SPRITES*ADDR_W  registered ROM address for each sprite.
- rom_q  in  NUM_SPRITES*COLOR_W  ROM data; valid exactly 1 cycle after rom_addr.
- out_valid  out  1  data, visible and sprite_id correspond to a pixel_valid input 3 cycles earlier.
- visible  out  1  a non-transparent sprite pixel was selected.
- sprite_id  out  clog2(NUM_SPRITES) (min 1)  index of the winning sprite; 0 when visible=0.
- data  out  COLOR_W  winning colour, or BG_COLOR.

## Operation
Shadow registers:
- On frame_start, pos_x, pos_y, frame_sel, flip and enable are copied into shadow registers.
- The pipeline uses only the shadow copies.
- When frame_start and pixel_valid occur in the same cycle, that pixel already uses the new values.

Stage 1 (hit test and address), per sprite i:
- rx = pixel_x - px and ry = pixel_y - py, computed in COORD_W+1 bits.
- hit_i = enable_i && pixel_valid && pixel_x >= px && pixel_y >= py && rx < SPR_W && ry < SPR_H. No wrap-around at the screen edge: a sprite at px = 1020 shows only columns 0..3.
- col = flip_i ? SPR_W-1-rx : rx.
- rom_addr_i <= frame_i*SPR_W*SPR_H + ry*SPR_W + col. This is full-width arithmetic, truncated to ADDR_W only at the register.
- Address 0 is a legal pixel.
- When hit_i is 0, rom_addr_i holds its previous value (no extra toggling).
- Registered alongside: hit vector and pixel_valid.

Stage 2 (ROM read):
- rom_q returns; hit and valid are delayed one cycle.
- opaque_i = hit_i && rom_q_i != TRANSPARENT.

Stage 3 (output register):
- The lowest i with opaque_i wins: data <= rom_q_i, visible <= 1, sprite_id <= i.
- With no winner: data <= BG_COLOR, visible <= 0, sprite_id <= 0.
- out_valid <= delayed pixel_valid.
- A transparent pixel of a higher-priority sprite lets lower-priority sprites show through.

Reset:
- out_valid=0, visible=0, sprite_id=0, data=BG_COLOR, rom_addr=0.
- All pipeline valid and hit bits are cleared.
- Shadow enable=0 and all other shadow fields are 0, so nothing is drawn until the first frame_start.

## Timing
- Latency is fixed at 3 cycles from pixel_valid to out_valid. Throughput is 1 pixel per cycle with no stalls.
- rom_addr appears 1 cycle after the pixel; rom_q is sampled 2 cycles after the pixel.
- rst asserted mid-line clears all in-flight pixels. out_valid is 0 in the cycle after rst and stays 0 until 3 cycles after the first pixel_valid following the deassertion of rst.
- frame_start has no effect on pixels already in flight.
- Input attribute changes without a frame_start have no effect.

## Test plan
- Single sprite, no flip: pos=(100,50), frame=0, ROM pattern = low byte of the address. Pixel (100,50) gives rom_addr=0 and data=8'h00 three cycles later. Pixel (249,50) gives addr 149. Pixel (250,50) gives visible=0 and data=8'h3B.
- Flip and frame: frame=2, flip=1, pixel (100,51) -> rom_addr = 2*23550 + 150 + 149 = 47399.
- Overlap: sprites 0 and 1 at the same position. Sprite 0 opaque -> sprite_id=0. Sprite 0 returns 8'hE3 -> sprite_id=1 with sprite 1's colour. Both return 8'hE3 -> visible=0.
- Shadow latch: change pos_x from 100 to 200 with no frame_start -> the hit at x=100 persists. Pulse frame_start together with a pixel at x=200 -> that pixel hits, with the address for rx=0.
- Edge clip: pos_x=1020, COORD_W=10, pixels x=1020..1023 hit. Pixel x=0 of the same row must not hit.
- Reset mid-stream: assert rst while 3 pixels are in flight -> out_valid=0 and data=8'h3B on the next cycle. The sprite is not drawn until a frame_start after the reset.
